onehot_req_arbiter: RTL

Upstream request-capture stage for the 4-to-2 encoder. It samples four level request lines, turns each rising edge into a pending event and arbitrates round-robin among pending events. It presents exactly one one-hot request at a time, with a valid/ready handshake, so the downstream 4-to-2 encoder always sees a legal one-hot input (or all-zero when idle).

---
 rtl/onehot_req_arbiter.sv | 97 +++++++++
 1 files changed

// File: rtl/onehot_req_arbiter.sv
// onehot_req_arbiter: upstream request-capture stage for the 4-to-2 encoder.
// It detects rising edges on four level request lines and records each one as
// a pending event. It then arbitrates round-robin among the pending events and
// presents a single registered one-hot request through a valid/ready handshake.
module onehot_req_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_in,
    input  logic       ready_in,
    output logic [3:0] onehot_out,
    output logic       valid_out,
    output logic [3:0] pending,
    output logic [3:0] overrun
);

    localparam int unsigned NREQ = 4;

    logic [3:0] req_prev_q, req_prev_d;
    logic [3:0] pending_q,  pending_d;
    logic [3:0] overrun_q,  overrun_d;
    logic [1:0] ptr_q,      ptr_d;
    logic [3:0] onehot_q,   onehot_d;
    logic       valid_q,    valid_d;

    logic [3:0] rise;
    logic       slot_free;
    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;
    logic [3:0] load_vec;

    // Round-robin search over registered pending, starting at ptr_q.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int unsigned j = 0; j < NREQ; j++) begin
            cand = ptr_q + 2'(j);
            if (!win_found && pending_q[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Edge capture, pending/overrun bookkeeping, and output slot loading.
    always_comb begin
        rise       = req_in & ~req_prev_q;
        slot_free  = !valid_q || ready_in;
        load_vec   = '0;
        if (slot_free && win_found) begin
            load_vec[win_idx] = 1'b1;
        end

        req_prev_d = req_in;
        // Clear the loaded bit first, then OR in new rises so that a rise
        // coinciding with its own load stays pending.
        pending_d  = (pending_q & ~load_vec) | rise;
        overrun_d  = overrun_q | (rise & pending_q & ~load_vec);

        onehot_d   = onehot_q;
        valid_d    = valid_q;
        ptr_d      = ptr_q;
        if (slot_free) begin
            onehot_d = load_vec;
            valid_d  = win_found;
            if (win_found) begin
                ptr_d = win_idx + 2'd1;
            end
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_prev_q <= '0;
            pending_q  <= '0;
            overrun_q  <= '0;
            ptr_q      <= '0;
            onehot_q   <= '0;
            valid_q    <= 1'b0;
        end else begin
            req_prev_q <= req_prev_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            ptr_q      <= ptr_d;
            onehot_q   <= onehot_d;
            valid_q    <= valid_d;
        end
    end

    assign onehot_out = onehot_q;
    assign valid_out  = valid_q;
    assign pending    = pending_q;
    assign overrun    = overrun_q;

endmodule
